pbus_master: RTL
================

Name: pbus_master

Overview:
- Wishbone initiator that drives the 8-bit, 12-bit-address peripheral/config bus (window 0xC00000–0xC00FFF) from the core's load/store port.
- Converts a single-cycle core request into one Wishbone classic cycle.
- Supports two completion modes, selected by system control:
  - SYNC mode: waits for WB_ACKi, with a timeout.
  - ASYNC mode: fixed wait-cycle count; ACK is ignored.
- Sits between the core LSU and the peripheral bus slave.

Parameters:
- ADDR_W, 12, Wishbone address width (byte address within the 4 KB window).
- TIMEOUT, 255, maximum SYNC-mode cycles with STB high and no ACK before the error path; range 1..255.
- ERR_DATA, 8'hFF, read data returned on timeout.

Ports:
- clk  in  1  system core clock
- rst  in  1  asynchronous reset, active-high
- SYNC_MODE  in  1  1 = complete on ACK; 0 = complete after fixed wait
- ASYNC_WAITCYCLE  in  7  extra strobe cycles in ASYNC mode
- cpu_req  in  1  single-cycle request strobe
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data, valid while cpu_done or cpu_err is high, held until next completion
- cpu_done  out  1  one-cycle successful completion pulse
- cpu_err  out  1  one-cycle timeout completion pulse
- cpu_busy  out  1  high from request acceptance until completion
- WB_ADRo  out  ADDR_W  bus address
- WB_DATo  out  8  bus write data
- WB_DATi  in  8  bus read data
- WB_WEo  out  1  write enable
- WB_CYCo  out  1  cycle valid
- WB_STBo  out  1  strobe
- WB_ACKi  in  1  slave acknowledge

Behaviour:
- Reset (asynchronous, immediate) forces all outputs to 0 and the FSM to IDLE. This includes cpu_rdata=0, and WB_ADRo/WB_DATo=0.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, BUS, DONE, ERR.
- IDLE:
  - cpu_req=1 → latch cpu_addr/cpu_we/cpu_wdata into WB_ADRo/WB_WEo/WB_DATo, latch SYNC_MODE into an internal mode bit, and go to BUS.
  - ASYNC mode: load the wait counter with ASYNC_WAITCYCLE.
  - SYNC mode: load the wait counter with TIMEOUT-1.
  - In the next cycle WB_CYCo=WB_STBo=1 and cpu_busy=1.
- BUS, SYNC mode:
  - WB_ACKi=1 at a clock edge → capture WB_DATi into cpu_rdata (reads only; writes leave cpu_rdata unchanged) and go to DONE.
  - Otherwise, counter==0 → go to ERR; else decrement.
  - ACK arriving on the same edge the counter hits 0 wins (DONE).
- BUS, ASYNC mode:
  - counter==0 → capture WB_DATi (reads) and go to DONE; else decrement.
  - STB is therefore high for exactly ASYNC_WAITCYCLE+1 cycles. ASYNC_WAITCYCLE=0 gives a single STB cycle.
  - WB_ACKi is ignored.
- DONE: CYC/STB=0, cpu_done=1 and cpu_busy=0 for one cycle, then IDLE.
- ERR: CYC/STB=0, cpu_err=1, cpu_rdata=ERR_DATA (reads only), cpu_busy=0 for one cycle, then IDLE.
- Latency:
  - SYNC mode: request edge to cpu_done = 2 + (ACK wait cycles).
  - ASYNC mode: ASYNC_WAITCYCLE + 3 cycles.
- Request and mode handling:
  - cpu_req is ignored in BUS, DONE and ERR; the core must observe cpu_busy.
  - A new request is accepted earliest in the IDLE cycle after DONE/ERR.
  - SYNC_MODE and ASYNC_WAITCYCLE changes during a transfer do not affect it; both are sampled at acceptance only.
- WB_ADRo/WB_DATo/WB_WEo are stable for the whole time CYC is high. They retain their values after the cycle ends.
- A stray WB_ACKi outside BUS is ignored.

Decomposition:
- Shared package pbus_pkg holds:
  - state encoding constants (IDLE=2'd0, BUS=2'd1, DONE=2'd2, ERR=2'd3)
  - PBUS_ADDR_W=12
  - default ERR_DATA
- One natural sub-module, pbus_wait_timer: an 8-bit loadable down-counter (load, value, dec, zero flag). It serves both the async wait count and the sync timeout.

Test Plan:
- SYNC read at addr 0x6F2, slave ACKs on the 3rd STB cycle with DATi=0x5A → STB high 3 cycles, cpu_done pulse, cpu_rdata=0x5A, WB_ADRo=0x6F2 throughout.
- ASYNC write, ASYNC_WAITCYCLE=3, addr 0x800, wdata 0xC3, ACK tied high → STB/CYC high exactly 4 cycles, WB_WEo=1, WB_DATo=0xC3, cpu_done 1 cycle later. Repeat with ASYNC_WAITCYCLE=0 → STB high 1 cycle.
- SYNC read, TIMEOUT=8, ACK never asserted → STB high 8 cycles, cpu_err pulse, cpu_rdata=0xFF, cpu_done stays 0.
- Back-to-back: second cpu_req while busy is dropped. A req in the IDLE cycle after DONE starts a new cycle. Toggling SYNC_MODE mid-transfer does not change the completion rule.
- Reset asserted on 2nd STB cycle of an ASYNC transfer → CYC/STB/cpu_busy go to 0 immediately (before the next edge), no cpu_done. A request after reset release completes normally.
- ACK and timeout coincide (ACK on the 8th cycle, TIMEOUT=8) → cpu_done, not cpu_err.

Source files
------------

// File: rtl/pbus_pkg.sv
// pbus_pkg: shared constants for the peripheral/config bus master.
//   ST_*           FSM state encodings (IDLE, BUS, DONE, ERR)
//   PBUS_ADDR_W    byte address width inside the 4 KB config window
//   PBUS_ERR_DATA  read data returned when a SYNC transfer times out
package pbus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam int         PBUS_ADDR_W   = 12;
  localparam logic [7:0] PBUS_ERR_DATA = 8'hFF;

endpackage

// File: rtl/pbus_master_if.sv
// pbus_master_if: Wishbone classic signals of the peripheral bus.
//   master modport: drives WB_ADRo/WB_DATo/WB_WEo/WB_CYCo/WB_STBo,
//                   receives WB_DATi/WB_ACKi
//   slave modport : the mirror image
interface pbus_master_if
  import pbus_pkg::*;
#(
  parameter int ADDR_W = PBUS_ADDR_W
);

  logic [ADDR_W-1:0] WB_ADRo;
  logic [7:0]        WB_DATo;
  logic [7:0]        WB_DATi;
  logic              WB_WEo;
  logic              WB_CYCo;
  logic              WB_STBo;
  logic              WB_ACKi;

  modport master (
    output WB_ADRo, WB_DATo, WB_WEo, WB_CYCo, WB_STBo,
    input  WB_DATi, WB_ACKi
  );

  modport slave (
    input  WB_ADRo, WB_DATo, WB_WEo, WB_CYCo, WB_STBo,
    output WB_DATi, WB_ACKi
  );

endinterface

// File: rtl/pbus_wait_timer.sv
// pbus_wait_timer: 8-bit loadable down-counter shared by the ASYNC wait
// count and the SYNC ACK timeout.
//   clk, rst : clock, asynchronous active-high reset
//   load     : load 'value' into the counter (has priority over dec)
//   value    : load value
//   dec      : decrement by one (saturates at zero)
//   zero     : counter currently equals zero
module pbus_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/pbus_master.sv
// pbus_master: turns a single-cycle core load/store request into one
// Wishbone classic cycle on the 8-bit peripheral/config bus.
//   clk, rst         : clock, asynchronous active-high reset
//   SYNC_MODE        : 1 = finish on WB_ACKi (with timeout), 0 = fixed wait
//   ASYNC_WAITCYCLE  : extra strobe cycles in ASYNC mode
//   cpu_req/we/addr/wdata : request strobe and payload (sampled in IDLE only)
//   cpu_rdata        : read data, held until the next completion
//   cpu_done/cpu_err : one-cycle success / timeout completion pulses
//   cpu_busy         : high from acceptance until completion
//   wb               : Wishbone master port
// Every output comes straight from a flop.
//
// state | meaning
// IDLE  | waiting for cpu_req
// BUS   | CYC/STB asserted, counting wait cycles or waiting for ACK
// DONE  | one-cycle cpu_done pulse
// ERR   | one-cycle cpu_err pulse after SYNC timeout
module pbus_master
  import pbus_pkg::*;
#(
  parameter int         ADDR_W   = PBUS_ADDR_W,
  parameter int         TIMEOUT  = 255,
  parameter logic [7:0] ERR_DATA = PBUS_ERR_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SYNC_MODE,
  input  logic [6:0]        ASYNC_WAITCYCLE,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              cpu_busy,
  pbus_master_if.master     wb
);

  // Counter runs TIMEOUT-1 .. 0 so STB stays high for exactly TIMEOUT cycles.
  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [7:0]        dat_q, dat_d;
  logic              we_q, we_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              cyc_q, cyc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              tmr_load;
  logic [7:0]        tmr_val;
  logic              tmr_dec;
  logic              tmr_zero;

  pbus_wait_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_val),
    .dec   (tmr_dec),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    cyc_d    = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = TO_LOAD;
    tmr_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          adr_d    = cpu_addr;
          dat_d    = cpu_wdata;
          we_d     = cpu_we;
          mode_d   = SYNC_MODE;
          tmr_load = 1'b1;
          tmr_val  = SYNC_MODE ? TO_LOAD : {1'b0, ASYNC_WAITCYCLE};
          cyc_d    = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_BUS;
        end
      end
      ST_BUS: begin
        // ACK is checked before the timeout so a coincident ACK still succeeds.
        if ((mode_q && wb.WB_ACKi) || (!mode_q && tmr_zero)) begin
          if (!we_q) rdata_d = wb.WB_DATi;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (mode_q && tmr_zero) begin
          if (!we_q) rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          tmr_dec = 1'b1;
          cyc_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      adr_q   <= '0;
      dat_q   <= 8'd0;
      we_q    <= 1'b0;
      rdata_q <= 8'd0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wb.WB_ADRo = adr_q;
  assign wb.WB_DATo = dat_q;
  assign wb.WB_WEo  = we_q;
  assign wb.WB_CYCo = cyc_q;
  assign wb.WB_STBo = cyc_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_done   = done_q;
  assign cpu_err    = err_q;
  assign cpu_busy   = busy_q;

endmodule
